// File: rtl/fft_stream_core.sv
// fft_stream_core: streaming in-place radix-2 DIT FFT (load, one butterfly per cycle, unload).
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (1/N_POINTS overall gain).
module fft_stream_core #(
    parameter int N_POINTS    = 64,
    parameter int LOG_2_WIDTH = 6,
    parameter int D_WIDTH     = 16,
    parameter int TW_WIDTH    = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_re,
    input  logic [D_WIDTH-1:0] in_im,
    input  logic               inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_re,
    output logic [D_WIDTH-1:0] out_im,
    output logic               out_last,
    output logic               busy
);
    localparam int TW_FRAC = TW_WIDTH - 2;
    localparam int A       = LOG_2_WIDTH;
    localparam int SW      = $clog2(LOG_2_WIDTH);
    localparam int PW      = D_WIDTH + TW_WIDTH + 1;
    localparam int EW      = D_WIDTH + 2;
    localparam int RND     = 1 << (TW_FRAC - 1);
    localparam logic [A-1:0]  LAST       = A'(N_POINTS - 1);
    localparam logic [A-1:0]  HALF_LAST  = A'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_2_WIDTH - 1);

    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;
    state_t state, state_n;

    logic [A-1:0]  cnt, rev, hmask, j, addr_a, addr_b;
    logic [A-2:0]  k;
    logic [SW-1:0] stage;
    logic [SW:0]   stage1;
    logic          inv_r, in_fire, out_fire, row_end, calc_done;
    logic signed [D_WIDTH-1:0]  mem_re [N_POINTS];
    logic signed [D_WIDTH-1:0]  mem_im [N_POINTS];
    logic signed [TW_WIDTH-1:0] tw_c [N_POINTS/2];
    logic signed [TW_WIDTH-1:0] tw_s [N_POINTS/2];
    logic signed [TW_WIDTH-1:0] w_re, w_im;
    logic signed [D_WIDTH-1:0]  a_re, a_im, b_re, b_im, na_re, na_im, nb_re, nb_im;
    logic signed [PW-1:0]       p_re, p_im;
    logic signed [D_WIDTH:0]    t_re, t_im, sa_re, sa_im, sb_re, sb_im;

    // Twiddle table folded at elaboration: round-half-away of 2^TW_FRAC*cos/sin
    function automatic logic signed [TW_WIDTH-1:0] tw_val(input int idx, input bit sine);
        real ang, v;
        ang = 6.283185307179586 * idx / N_POINTS;
        v = (sine ? $sin(ang) : $cos(ang)) * real'(1 << TW_FRAC);
        return TW_WIDTH'(v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
    endfunction

    for (genvar i = 0; i < N_POINTS / 2; i++) begin : g_tw
        assign tw_c[i] = tw_val(i, 1'b0);
        assign tw_s[i] = tw_val(i, 1'b1);
    end

    assign in_ready  = state == LOAD;
    assign busy      = state != LOAD;
    assign out_valid = state == UNLOAD;
    assign out_last  = out_valid && cnt == LAST;
    assign out_re    = out_valid ? mem_re[cnt] : '0;
    assign out_im    = out_valid ? mem_im[cnt] : '0;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign row_end   = cnt == HALF_LAST;
    assign calc_done = row_end && stage == LAST_STAGE;

    always_comb begin
        rev = '0;
        for (int b = 0; b < A; b++) rev[b] = cnt[A-1-b];
        // cnt enumerates butterflies: low bits are j, high bits are the group g
        stage1 = (SW+1)'(stage) + (SW+1)'(1);
        hmask  = (A'(1) << stage) - A'(1);
        j      = cnt & hmask;
        addr_a = ((cnt >> stage) << stage1) | j;
        addr_b = addr_a | (hmask + A'(1));
        k      = (A-1)'(j << (SW'(A - 1) - stage));
        w_re   = tw_c[k];
        w_im   = inv_r ? tw_s[k] : -tw_s[k];
        a_re   = mem_re[addr_a];
        a_im   = mem_im[addr_a];
        b_re   = mem_re[addr_b];
        b_im   = mem_im[addr_b];
        p_re   = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        p_im   = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        t_re   = (D_WIDTH+1)'((p_re + PW'(RND)) >>> TW_FRAC);
        t_im   = (D_WIDTH+1)'((p_im + PW'(RND)) >>> TW_FRAC);
        sa_re  = (D_WIDTH+1)'(a_re) + t_re;
        sa_im  = (D_WIDTH+1)'(a_im) + t_im;
        sb_re  = (D_WIDTH+1)'(a_re) - t_re;
        sb_im  = (D_WIDTH+1)'(a_im) - t_im;
`ifdef FFT_STAGE_SCALE_EN
        na_re  = D_WIDTH'((EW'(sa_re) + EW'(1)) >>> 1);
        na_im  = D_WIDTH'((EW'(sa_im) + EW'(1)) >>> 1);
        nb_re  = D_WIDTH'((EW'(sb_re) + EW'(1)) >>> 1);
        nb_im  = D_WIDTH'((EW'(sb_im) + EW'(1)) >>> 1);
`else
        na_re  = D_WIDTH'(sa_re);
        na_im  = D_WIDTH'(sa_im);
        nb_re  = D_WIDTH'(sb_re);
        nb_im  = D_WIDTH'(sb_im);
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (in_fire && cnt == LAST) state_n = CALC;
            CALC:    if (calc_done) state_n = UNLOAD;
            UNLOAD:  if (out_fire && cnt == LAST) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            stage <= '0;
            inv_r <= 1'b0;
        end else begin
            state <= state_n;
            if (in_fire) begin
                cnt <= cnt + A'(1);
                if (cnt == '0) inv_r <= inverse;
            end
            if (state == CALC) begin
                cnt <= row_end ? '0 : cnt + A'(1);
                if (row_end) stage <= calc_done ? '0 : stage + SW'(1);
            end
            if (out_fire) cnt <= cnt + A'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re[rev] <= in_re;
            mem_im[rev] <= in_im;
        end
        if (state == CALC) begin
            mem_re[addr_a] <= na_re;
            mem_im[addr_a] <= na_im;
            mem_re[addr_b] <= nb_re;
            mem_im[addr_b] <= nb_im;
        end
    end
endmodule

// File: tb/tb_fft_stream_core.sv
// tb_fft_stream_core: scoreboard bench for fft_stream_core, default build (64 points, no scaling).
module tb_fft_stream_core;
    localparam int N = 64;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, inverse = 1'b0, out_ready = 1'b1;
    logic [15:0] in_re = '0, in_im = '0;
    logic        in_ready, out_valid, out_last, busy;
    logic [15:0] out_re, out_im;

    typedef struct { int re; int im; int tol; } exp_t;
    exp_t        sb[$];
    exp_t        e_cur;
    int          n_checks = 0, n_fail = 0;
    int          xr [N], xi [N], orig_re [N], orig_im [N], cap_re [N], cap_im [N];
    int          bidx = 0, calc_cyc = 0;
    bit          bp_out = 1'b0, stalled = 1'b0;
    logic [15:0] held_re, held_im;
    logic        held_last;

    fft_stream_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inverse(inverse),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_checks++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Reference DFT in floating point, unscaled
    task automatic push_dft(input bit inv, input int tol);
        real sr, si, th, sg;
        exp_t e;
        sg = inv ? -1.0 : 1.0;
        for (int kk = 0; kk < N; kk++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 6.283185307179586 * ((n * kk) % N) / N;
                sr += xr[n] * $cos(th) + sg * xi[n] * $sin(th);
                si += xi[n] * $cos(th) - sg * xr[n] * $sin(th);
            end
            e.re = int'(sr);
            e.im = int'(si);
            e.tol = tol;
            sb.push_back(e);
        end
    endtask

    task automatic send(input bit inv, input bit bp);
        int i = 0, guard = 0;
        bit fire;
        calc_cyc = 0;
        while (i < N && guard < 5000) begin
            in_valid = bp ? 1'($urandom_range(1)) : 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            inverse = (i == 0) ? inv : ~inv;
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            guard++;
        end
        in_valid = 1'b0;
        check("load_beats", i, N);
    endtask

    task automatic wait_frame();
        int guard = 0;
        while (sb.size() != 0 && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("frame_drained", sb.size(), 0);
        check("calc_cycles", calc_cyc, 192);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < N; n++) begin
            xr[n] = 0;
            xi[n] = 0;
        end
        xr[0] = 100;
    endtask

    always @(negedge clk) begin
        if (!rst && busy && !out_valid) calc_cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = bp_out ? 1'($urandom_range(1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            bidx = 0;
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled) begin
                check("hold_re", out_re, held_re);
                check("hold_im", out_im, held_im);
                check("hold_last", out_last, held_last);
            end
            if (out_ready) begin
                if (sb.size() == 0) check("sb_empty", sb.size(), 1);
                else begin
                    e_cur = sb.pop_front();
                    check($sformatf("re[%0d]", bidx), $signed(out_re), e_cur.re, e_cur.tol);
                    check($sformatf("im[%0d]", bidx), $signed(out_im), e_cur.im, e_cur.tol);
                    check($sformatf("last[%0d]", bidx), out_last, int'(bidx == N - 1));
                    cap_re[bidx] = $signed(out_re);
                    cap_im[bidx] = $signed(out_im);
                end
                bidx = (bidx + 1) % N;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_re = out_re;
                held_im = out_im;
                held_last = out_last;
            end
        end else stalled = 1'b0;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int guard;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_last", out_last, 0);
        check("reset_out_re", out_re, 0);
        check("reset_out_im", out_im, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", in_ready, 1);

        set_impulse();
        push_dft(1'b0, 0); send(1'b0, 1'b0); wait_frame();
        push_dft(1'b1, 0); send(1'b1, 1'b0); wait_frame();

        for (int n = 0; n < N; n++) begin
            xr[n] = 16;
            xi[n] = 0;
        end
        push_dft(1'b0, 1); send(1'b0, 1'b0); wait_frame();

        for (int n = 0; n < N; n++) begin
            xr[n] = int'($urandom_range(400)) - 200;
            xi[n] = int'($urandom_range(400)) - 200;
        end
        push_dft(1'b0, 64); send(1'b0, 1'b0); wait_frame();

        // Round trip: forward then inverse of the captured spectrum gives 64*x
        for (int n = 0; n < N; n++) begin
            orig_re[n] = int'($urandom_range(200)) - 100;
            orig_im[n] = int'($urandom_range(200)) - 100;
            xr[n] = orig_re[n];
            xi[n] = orig_im[n];
        end
        push_dft(1'b0, 64); send(1'b0, 1'b0); wait_frame();
        for (int n = 0; n < N; n++) begin
            xr[n] = cap_re[n];
            xi[n] = cap_im[n];
            e_cur.re = 64 * orig_re[n];
            e_cur.im = 64 * orig_im[n];
            e_cur.tol = 64;
            sb.push_back(e_cur);
        end
        send(1'b1, 1'b0); wait_frame();

        bp_out = 1'b1;
        for (int n = 0; n < N; n++) begin
            xr[n] = orig_re[n];
            xi[n] = orig_im[n];
        end
        push_dft(1'b0, 64); send(1'b0, 1'b1); wait_frame();
        set_impulse();
        push_dft(1'b0, 0); send(1'b0, 1'b1); wait_frame();
        bp_out = 1'b0;

        send(1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        check("mid_calc_busy", busy, 1);
        pulse_rst();
        push_dft(1'b0, 0); send(1'b0, 1'b0); wait_frame();

        push_dft(1'b0, 0); send(1'b0, 1'b0);
        guard = 0;
        while (bidx < 10 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_unload_reached", int'(bidx >= 10), 1);
        pulse_rst();
        push_dft(1'b0, 0); send(1'b0, 1'b0); wait_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
